tf_addr_gen: RTL and testbench
==============================

# tf_addr_gen

Twiddle-factor address generator for the radix-2, two-butterfly-per-cycle FFT core. It walks the stage and butterfly counters of one FFT frame and drives the twiddle ROM exponents on `EXP0`/`EXP1`, one pair per cycle. It sits directly in front of the twiddle ROM: `EXP0`/`EXP1` connect straight to the ROM address ports. `TF_VLD` marks the cycle in which the ROM's registered `TF0`/`TF1` outputs are valid for the butterfly datapath.

## Interface
- `LOG2N`, 5, log2 of FFT size N. Supported range 3..6. ROM depth is N/2, and exponent width is `LOG2N-1` (default 4, i.e. 16 entries).
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `START` input 1: frame start request. Sampled only in IDLE.
- `HOLD` input 1: datapath stall. Freezes the generator while high.
- `EXP0` output `LOG2N-1`: exponent for the even butterfly. Drives ROM port 0.
- `EXP1` output `LOG2N-1`: exponent for the odd butterfly. Drives ROM port 1.
- `EXP_VLD` output 1: `EXP0`/`EXP1` hold a live pair this cycle.
- `TF_VLD` output 1: ROM outputs this cycle belong to a pair issued the previous cycle.
- `STAGE` output 3: current stage index, 0..`LOG2N-1`.
- `BUSY` output 1: frame in progress (RUN or DRAIN).
- `DONE` output 1: single-cycle end-of-frame pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when `START`=1. Counters cleared: stage s=0, cycle count c=0.
  - RUN: each cycle define FIRE = `EXP_VLD` & ~`HOLD`.
    - On FIRE, c increments.
    - When c wraps at N/4-1, c returns to 0 and s increments.
    - FIRE on the last pair (s=`LOG2N-1`, c=N/4-1) → DRAIN.
  - DRAIN → IDLE unconditionally after one cycle. `DONE`=1 only during DRAIN.
- Butterfly indices per cycle: b0=2c, b1=2c+1.
- Exponent, DIF (default): exp = (b & ((N>>(s+1))-1)) << s, truncated to `LOG2N-1` bits.
- `EXP_VLD`=1 throughout RUN. `BUSY`=1 in RUN and DRAIN.
- `HOLD`=1 freezes all state. `EXP0`/`EXP1` are held, so the ROM re-reads the same address and `TF0`/`TF1` stay stable.
- `START` is ignored outside IDLE.
- `HOLD` in IDLE or DRAIN has no effect.
- In IDLE, `EXP0`/`EXP1` are driven to 0.
- `RST` asserted mid-frame: immediate return to IDLE and all outputs to reset values. No `DONE` pulse.

## Timing
- Reset values: `EXP0`=0, `EXP1`=0, `EXP_VLD`=0, `TF_VLD`=0, `STAGE`=0, `BUSY`=0, `DONE`=0.
- All outputs are registered. `EXP0`, `EXP1` and `STAGE` are registered state-driven values.
- `START` sampled at edge k → RUN from cycle k+1, with the first pair (exp 0,1) on `EXP0`/`EXP1` in cycle k+1.
- `TF_VLD` in cycle t+1 equals FIRE in cycle t. This matches the ROM's one-cycle registered read latency.
- With no `HOLD`, a frame occupies `LOG2N`·N/4 RUN cycles (40 at default) plus 1 DRAIN cycle.
  - The final `TF_VLD` coincides with `DONE`.
  - `BUSY` falls the cycle after `DONE`.
- Earliest back-to-back restart: `START` sampled in the first IDLE cycle after `DONE`.

## Configuration
- `TFAG_DIT_EN` defined:
  - DIT sequence: exp = (b & ((1<<s)-1)) << (`LOG2N`-1-s).
  - Stage 0 is all zeros; the last stage is exp=b.
- `TFAG_DIT_EN` undefined: DIF sequence as above.
- Counters, FSM and timing are identical in both modes.

## Structure
- Package `tfag_pkg` holds:
  - the FSM state enum (IDLE/RUN/DRAIN);
  - localparams derived from `LOG2N`: N, N/4, exponent width, last stage index;
  - no ROM contents.
- Sub-module `tfag_exp_calc`:
  - combinational (s, b) → exp;
  - contains the `TFAG_DIT_EN` selection;
  - instantiated twice, once for b0 and once for b1.

## Test plan
- Reset mid-RUN (`RST` pulse at RUN cycle 10) → next cycle all outputs 0 and state IDLE. No `DONE` pulse. `START` then runs a full 40-cycle frame.
- DIF, `LOG2N`=5, `START`, no `HOLD`:
  - stage 0, c=3 → `EXP0`=6, `EXP1`=7;
  - stage 1, c=5 → 4, 6;
  - stage 2, c=2 → 0, 4;
  - stage 4 → all 0;
  - `DONE` exactly 41 cycles after the first RUN cycle.
- `HOLD` high for 3 cycles at stage 1, c=2:
  - `EXP0`/`EXP1`/`STAGE` frozen;
  - `TF_VLD`=0 for the 3 cycles following the first held cycle;
  - `DONE` delayed by exactly 3 cycles.
- `START` pulsed during RUN and DRAIN → ignored; a single `DONE` only.
- `TFAG_DIT_EN` defined, `LOG2N`=5:
  - stage 0 → all 0;
  - stage 1, c=2 (b=4,5) → `EXP0`=0, `EXP1`=8;
  - stage 4, c=7 → 14, 15.
- Connected to the twiddle ROM loaded with index-tagged data: on every `TF_VLD` cycle, `TF0`/`TF1` equal the entries at the previous cycle's `EXP0`/`EXP1`. 40 valid pairs in total.

Source files
------------

// File: rtl/tfag_pkg.sv
// Shared FSM state type and LOG2N-derived sizing helpers for the twiddle address generator.
package tfag_pkg;

  localparam int unsigned Log2nDef = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } tfag_state_e;

  function automatic int unsigned fft_n(input int unsigned log2n);
    return 32'd1 << log2n;
  endfunction

  function automatic int unsigned quarter_n(input int unsigned log2n);
    return fft_n(log2n) >> 2;
  endfunction

  function automatic int unsigned exp_width(input int unsigned log2n);
    return log2n - 1;
  endfunction

  function automatic int unsigned last_stage(input int unsigned log2n);
    return log2n - 1;
  endfunction

endpackage

// File: rtl/tf_addr_gen_if.sv
// Control/exponent bundle between the twiddle address generator and its consumers.
interface tf_addr_gen_if #(
  parameter int unsigned EW = 4
);
  logic          start;
  logic          hold;
  logic [EW-1:0] exp0;
  logic [EW-1:0] exp1;
  logic          exp_vld;
  logic          tf_vld;
  logic [2:0]    stage;
  logic          busy;
  logic          done;

  modport master (
    input  start, hold,
    output exp0, exp1, exp_vld, tf_vld, stage, busy, done
  );

  modport slave (
    output start, hold,
    input  exp0, exp1, exp_vld, tf_vld, stage, busy, done
  );
endinterface

// File: rtl/tfag_exp_calc.sv
// Combinational (stage, butterfly index) -> twiddle exponent.
// DIF ordering by default; define TFAG_DIT_EN for DIT ordering.
module tfag_exp_calc #(
  parameter int unsigned LOG2N = 5,
  localparam int unsigned EW   = LOG2N - 1
) (
  input  logic [2:0]    stage,
  input  logic [EW-1:0] bidx,
  output logic [EW-1:0] texp
);

  localparam logic [2:0] EwS = 3'(EW);

  logic [EW-1:0] one_w;
  logic [EW-1:0] mask;
  logic [2:0]    rshift;

  // Masks are built modulo 2^EW, so 1<<EW wraps to 0 and 0-1 gives all ones.
  always_comb begin
    one_w    = '0;
    one_w[0] = 1'b1;
    rshift   = EwS - stage;
`ifdef TFAG_DIT_EN
    mask = (one_w << stage) - one_w;
    texp = (bidx & mask) << rshift;
`else
    mask = (one_w << rshift) - one_w;
    texp = (bidx & mask) << stage;
`endif
  end

endmodule

// File: rtl/tf_addr_gen.sv
// Twiddle-factor address generator: walks stage/pair counters of one FFT frame and
// issues registered ROM exponents. Define TFAG_DIT_EN for the DIT exponent sequence.
module tf_addr_gen
  import tfag_pkg::*;
#(
  parameter int unsigned LOG2N = Log2nDef
) (
  input logic           clk,
  input logic           rst,
  tf_addr_gen_if.master bus
);

  localparam int unsigned EW = exp_width(LOG2N);
  localparam int unsigned CW = EW - 1;
  localparam logic [2:0]    LastS = 3'(last_stage(LOG2N));
  localparam logic [CW-1:0] CLast = CW'(quarter_n(LOG2N) - 1);

  tfag_state_e   state_q;
  logic [2:0]    s_q, s_nxt;
  logic [CW-1:0] c_q, c_nxt;
  logic [EW-1:0] exp0_q, exp1_q, exp0_nxt, exp1_nxt;
  logic          exp_vld_q, tf_vld_q, busy_q, done_q;
  logic          fire, last_pair;

  assign fire      = exp_vld_q & ~bus.hold;
  assign last_pair = (s_q == LastS) && (c_q == CLast);

  // Counter values for the pair that becomes visible after the next FIRE (or START).
  always_comb begin
    s_nxt = '0;
    c_nxt = '0;
    if (state_q == StRun) begin
      if (c_q == CLast) begin
        s_nxt = s_q + 3'd1;
      end else begin
        s_nxt = s_q;
        c_nxt = c_q + CW'(1);
      end
    end
  end

  tfag_exp_calc #(.LOG2N(LOG2N)) u_exp_even (
    .stage (s_nxt),
    .bidx  ({c_nxt, 1'b0}),
    .texp  (exp0_nxt)
  );

  tfag_exp_calc #(.LOG2N(LOG2N)) u_exp_odd (
    .stage (s_nxt),
    .bidx  ({c_nxt, 1'b1}),
    .texp  (exp1_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      s_q       <= '0;
      c_q       <= '0;
      exp0_q    <= '0;
      exp1_q    <= '0;
      exp_vld_q <= 1'b0;
      tf_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tf_vld_q <= fire;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StRun;
            s_q       <= '0;
            c_q       <= '0;
            exp0_q    <= exp0_nxt;
            exp1_q    <= exp1_nxt;
            exp_vld_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StRun: begin
          if (fire) begin
            if (last_pair) begin
              state_q   <= StDrain;
              exp0_q    <= '0;
              exp1_q    <= '0;
              exp_vld_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              s_q    <= s_nxt;
              c_q    <= c_nxt;
              exp0_q <= exp0_nxt;
              exp1_q <= exp1_nxt;
            end
          end
        end
        StDrain: begin
          state_q <= StIdle;
          s_q     <= '0;
          c_q     <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.exp0    = exp0_q;
  assign bus.exp1    = exp1_q;
  assign bus.exp_vld = exp_vld_q;
  assign bus.tf_vld  = tf_vld_q;
  assign bus.stage   = s_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_tf_addr_gen.sv
// Directed self-checking bench for tf_addr_gen (LOG2N=5); honours TFAG_DIT_EN for expectations.
module tb_tf_addr_gen;
  import tfag_pkg::*;

  localparam int unsigned L  = 5;
  localparam int unsigned EW = L - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tf_addr_gen_if #(.EW(EW)) bus ();

  tf_addr_gen #(.LOG2N(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Twiddle ROM with index-tagged contents and a one-cycle registered read.
  logic [7:0] rom_tf0, rom_tf1;
  always @(posedge clk) begin
    rom_tf0 <= 8'h40 + 8'(bus.exp0);
    rom_tf1 <= 8'h40 + 8'(bus.exp1);
  end

`ifdef TFAG_DIT_EN
  int vec_r  [6] = '{0, 3, 10, 24, 33, 39};
  int vec_e0 [6] = '{0, 0, 0, 0, 2, 14};
  int vec_e1 [6] = '{0, 0, 8, 2, 3, 15};
  localparam int HoldE0 = 0;
  localparam int HoldE1 = 8;
`else
  int vec_r  [6] = '{0, 3, 13, 18, 32, 39};
  int vec_e0 [6] = '{0, 6, 4, 0, 0, 0};
  int vec_e1 [6] = '{1, 7, 6, 4, 0, 0};
  localparam int HoldE0 = 8;
  localparam int HoldE1 = 10;
`endif

  function automatic int model_exp(input int s, input int b);
    int n;
    int e;
    n = 1 << L;
`ifdef TFAG_DIT_EN
    e = (b & ((1 << s) - 1)) << (L - 1 - s);
`else
    e = (b & ((n >> (s + 1)) - 1)) << s;
`endif
    return e % (n / 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    int run_cnt;
    int done_cnt;
    int done_cyc;
    checks++;
    if ({bus.exp0, bus.exp1, bus.stage} !== '0) begin
      errors++;
      $display("FAIL reset_values: exp0=%0d exp1=%0d stage=%0d required 0 0 0",
               bus.exp0, bus.exp1, bus.stage);
    end
    checks++;
    if ({bus.exp_vld, bus.tf_vld, bus.busy, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: vld/tfv/busy/done=%b required 0000",
               {bus.exp_vld, bus.tf_vld, bus.busy, bus.done});
    end
    rst = 1'b0;
    tick();
    start_frame();
    for (int i = 1; i < 10; i++) tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.stage !== 3'd1) begin
      errors++;
      $display("FAIL pre_reset_run: busy=%b stage=%0d required 1 1", bus.busy, bus.stage);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.exp0, bus.exp1, bus.exp_vld, bus.busy, bus.stage} !== '0) begin
      errors++;
      $display("FAIL async_reset: exp0=%0d exp1=%0d vld=%b busy=%b stage=%0d required all 0",
               bus.exp0, bus.exp1, bus.exp_vld, bus.busy, bus.stage);
    end
    tick();
    checks++;
    if ({bus.exp_vld, bus.tf_vld, bus.busy, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_next_cycle: vld/tfv/busy/done=%b required 0000",
               {bus.exp_vld, bus.tf_vld, bus.busy, bus.done});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done=%b busy=%b required 0 0", bus.done, bus.busy);
    end
    start_frame();
    run_cnt  = 0;
    done_cnt = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (bus.exp_vld === 1'b1) run_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      tick();
    end
    checks++;
    if (run_cnt != 40 || done_cnt != 1 || done_cyc != 41) begin
      errors++;
      $display("FAIL frame_after_reset: run=%0d dones=%0d done_cyc=%0d required 40 1 41",
               run_cnt, done_cnt, done_cyc);
    end
  endtask

  task automatic test_sequence();
    int done_cnt;
    int done_cyc;
    done_cnt = 0;
    done_cyc = 0;
    start_frame();
    for (int cyc = 1; cyc <= 43; cyc++) begin
      for (int v = 0; v < 6; v++) begin
        if (cyc - 1 == vec_r[v]) begin
          checks++;
          if (bus.exp0 !== EW'(vec_e0[v]) || bus.exp1 !== EW'(vec_e1[v]) ||
              bus.stage !== 3'(vec_r[v] / 8)) begin
            errors++;
            $display("FAIL seq_pair_r%0d: exp=%0d,%0d stage=%0d required %0d,%0d stage %0d",
                     vec_r[v], bus.exp0, bus.exp1, bus.stage, vec_e0[v], vec_e1[v],
                     vec_r[v] / 8);
          end
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == 41) begin
        checks++;
        if (bus.tf_vld !== 1'b1 || bus.busy !== 1'b1 || bus.exp_vld !== 1'b0) begin
          errors++;
          $display("FAIL seq_drain: tfv=%b busy=%b vld=%b required 1 1 0",
                   bus.tf_vld, bus.busy, bus.exp_vld);
        end
      end
      if (cyc == 42) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.tf_vld !== 1'b0 || bus.exp0 !== '0) begin
          errors++;
          $display("FAIL seq_idle: busy=%b tfv=%b exp0=%0d required 0 0 0",
                   bus.busy, bus.tf_vld, bus.exp0);
        end
      end
      tick();
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 41) begin
      errors++;
      $display("FAIL seq_done: dones=%0d done_cyc=%0d required 1 41", done_cnt, done_cyc);
    end
  endtask

  task automatic test_hold();
    int done_cnt;
    int done_cyc;
    done_cnt = 0;
    done_cyc = 0;
    start_frame();
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (cyc >= 11 && cyc <= 14) begin
        checks++;
        if (bus.exp0 !== EW'(HoldE0) || bus.exp1 !== EW'(HoldE1) || bus.stage !== 3'd1) begin
          errors++;
          $display("FAIL hold_frozen_c%0d: exp=%0d,%0d stage=%0d required %0d,%0d stage 1",
                   cyc, bus.exp0, bus.exp1, bus.stage, HoldE0, HoldE1);
        end
      end
      if (cyc >= 11 && cyc <= 15) begin
        checks++;
        if (bus.tf_vld !== ((cyc == 11 || cyc == 15) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL hold_tf_vld_c%0d: tf_vld=%b required %b", cyc, bus.tf_vld,
                   (cyc == 11 || cyc == 15));
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      bus.hold = (cyc >= 11 && cyc <= 13);
      tick();
    end
    bus.hold = 1'b0;
    checks++;
    if (done_cnt != 1 || done_cyc != 44) begin
      errors++;
      $display("FAIL hold_done: dones=%0d done_cyc=%0d required 1 44", done_cnt, done_cyc);
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt;
    int done_cyc;
    done_cnt = 0;
    done_cyc = 0;
    start_frame();
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == 43) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.exp_vld !== 1'b0) begin
          errors++;
          $display("FAIL start_in_drain: busy=%b vld=%b required 0 0", bus.busy, bus.exp_vld);
        end
      end
      bus.start = (cyc == 5 || cyc == 41);
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (done_cnt != 1 || done_cyc != 41) begin
      errors++;
      $display("FAIL start_ignored_done: dones=%0d done_cyc=%0d required 1 41",
               done_cnt, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int s;
    int c;
    bit done_seen;
    done_seen = 1'b0;
    start_frame();
    for (int cyc = 1; cyc <= 41; cyc++) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      if (cyc < 41) tick();
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL b2b_first_done: done seen=%b required 1", done_seen);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b required 0", bus.busy);
    end
    start_frame();
    checks++;
    if (bus.exp_vld !== 1'b1 || bus.busy !== 1'b1 || bus.exp0 !== EW'(model_exp(0, 0)) ||
        bus.exp1 !== EW'(model_exp(0, 1))) begin
      errors++;
      $display("FAIL b2b_restart: vld=%b busy=%b exp=%0d,%0d required 1 1 %0d,%0d",
               bus.exp_vld, bus.busy, bus.exp0, bus.exp1, model_exp(0, 0), model_exp(0, 1));
    end
    k = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (bus.tf_vld === 1'b1) begin
        s = k / 8;
        c = k % 8;
        checks++;
        if (rom_tf0 !== 8'(8'h40 + model_exp(s, 2 * c)) ||
            rom_tf1 !== 8'(8'h40 + model_exp(s, 2 * c + 1))) begin
          errors++;
          $display("FAIL rom_pair_%0d: tf=%h,%h required %h,%h", k, rom_tf0, rom_tf1,
                   8'(8'h40 + model_exp(s, 2 * c)), 8'(8'h40 + model_exp(s, 2 * c + 1)));
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k != 40) begin
      errors++;
      $display("FAIL rom_pair_count: pairs=%0d required 40", k);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    #2 rst = 1'b1;
    tick();
    test_reset();
    tick();
    test_sequence();
    tick();
    test_hold();
    tick();
    test_start_ignored();
    tick();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
